// File: rtl/if_id_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue_if
// Description : Handshake bundle between instruction fetch and decode that
//               goes through the IF/ID queue.
//
//               Fetch side : flush, in_valid, in_ready, in_PC, in_Instruction
//               Decode side: out_valid, out_ready, out_PC, and the decoded
//                            fields out_Opcode, out_rs, out_rt, out_rd,
//                            out_shamt, out_Funct and out_Imm16
//               Status     : count (current occupancy)
//
//               master : driven by the pipeline around the queue
//               slave  : seen by the queue itself
// Revision    : 1.0 - initial release
// ============================================================================
interface if_id_queue_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 2
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [PC_W-1:0]  in_PC;
  logic [31:0]      in_Instruction;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_PC;
  logic [5:0]       out_Opcode;
  logic [4:0]       out_rs;
  logic [4:0]       out_rt;
  logic [4:0]       out_rd;
  logic [4:0]       out_shamt;
  logic [5:0]       out_Funct;
  logic [15:0]      out_Imm16;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_PC, in_Instruction, out_ready,
    input  in_ready, out_valid, out_PC, out_Opcode, out_rs, out_rt, out_rd,
           out_shamt, out_Funct, out_Imm16, count
  );

  modport slave (
    input  flush, in_valid, in_PC, in_Instruction, out_ready,
    output in_ready, out_valid, out_PC, out_Opcode, out_rs, out_rt, out_rd,
           out_shamt, out_Funct, out_Imm16, count
  );
endinterface
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue
// Description : DEPTH-entry IF/ID pipeline buffer for the five-stage MIPS
//               core. Fetch pushes {PC, instruction} with a valid/ready
//               handshake. Decode sees the head entry already split into
//               MIPS fields. flush squashes every queued entry and the
//               instruction offered in the same cycle.
//
//               Ports:
//                 clk  - rising-edge clock
//                 rst  - asynchronous reset, active low
//                 bus  - if_id_queue_if.slave, which carries the handshakes,
//                        the decoded head and the occupancy count
//
//               Parameters:
//                 PC_W  - PC width
//                 DEPTH - entry count, power of two, at least 2
//                 CNT_W - occupancy width (derived, do not override)
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  if_id_queue_if.slave bus
);

  localparam int c_PTR_W = $clog2(DEPTH);

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [PC_W-1:0]    r_pc_mem    [DEPTH];
  logic [31:0]        r_instr_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_in_ready;

  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_out_valid;
  logic               w_push;
  logic               w_pop;
  logic [PC_W-1:0]    w_head_pc;
  logic [31:0]        w_head_instr;

  // --------------------------------------------------------------------------
  // Handshake qualification. flush overrides both sides: the offered
  // instruction is dropped and decode's consume is ignored.
  // --------------------------------------------------------------------------
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid  & r_in_ready  & ~bus.flush;
  assign w_pop       = w_out_valid   & bus.out_ready & ~bus.flush;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pointers, count and ready.
  // in_ready is a flop that is loaded with "not full" from the next count.
  // out_ready therefore only reaches in_ready through a register. A pop from
  // a full queue raises in_ready after the edge, so there is no refill in the
  // same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else if (bus.flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt < CNT_W'(DEPTH));
    end
  end

  // --------------------------------------------------------------------------
  // Entry storage. It has no reset, because stale contents are never seen:
  // the output mask hides everything while the queue is empty. Each entry
  // loads only when it is the write target, so the other entries hold.
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (w_push && (r_wr_ptr == c_PTR_W'(gi))) begin
          r_pc_mem[gi]    <= bus.in_PC;
          r_instr_mem[gi] <= bus.in_Instruction;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Head decode. A bubble is forced to all zeros. Decode then sees
  // sll $0,$0,0 (a NOP) at PC 0 and needs no separate valid qualification.
  // --------------------------------------------------------------------------
  assign w_head_pc    = w_out_valid ? r_pc_mem[r_rd_ptr]    : '0;
  assign w_head_instr = w_out_valid ? r_instr_mem[r_rd_ptr] : '0;

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.count      = r_count;
  assign bus.out_PC     = w_head_pc;
  assign bus.out_Opcode = w_head_instr[31:26];
  assign bus.out_rs     = w_head_instr[25:21];
  assign bus.out_rt     = w_head_instr[20:16];
  assign bus.out_rd     = w_head_instr[15:11];
  assign bus.out_shamt  = w_head_instr[10:6];
  assign bus.out_Funct  = w_head_instr[5:0];
  assign bus.out_Imm16  = w_head_instr[15:0];

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_queue
// Description : Self-checking bench for if_id_queue. A DEPTH=2 and a DEPTH=4
//               instance get identical stimulus. A queue-based reference
//               model per instance holds the expected contents. A monitor
//               compares each instance's head, count and ready against its
//               model on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_PC = '0;
  logic [31:0] in_Instruction = '0;

  always #5 clk = ~clk;

  if_id_queue_if #(.PC_W(32), .CNT_W(2)) b2 ();
  if_id_queue_if #(.PC_W(32), .CNT_W(3)) b4 ();

  assign b2.flush = flush;          assign b4.flush = flush;
  assign b2.in_valid = in_valid;    assign b4.in_valid = in_valid;
  assign b2.in_PC = in_PC;          assign b4.in_PC = in_PC;
  assign b2.in_Instruction = in_Instruction;
  assign b4.in_Instruction = in_Instruction;
  assign b2.out_ready = out_ready;  assign b4.out_ready = out_ready;

  if_id_queue #(.PC_W(32), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  if_id_queue #(.PC_W(32), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  int total = 0;
  int bad   = 0;

  // Expected contents, oldest first: {PC, instruction}
  logic [63:0] q2[$];
  logic [63:0] q4[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. It is a bounded FIFO. Ready is "not full" as of the
  // last edge. flush empties it. Reset empties it at once.
  always @(posedge clk or negedge rst) begin : model
    bit p2, o2, p4, o4;
    if (!rst) begin
      q2.delete();
      q4.delete();
    end else if (flush) begin
      q2.delete();
      q4.delete();
    end else begin
      p2 = in_valid && (q2.size() < 2);
      o2 = out_ready && (q2.size() != 0);
      p4 = in_valid && (q4.size() < 4);
      o4 = out_ready && (q4.size() != 0);
      if (o2) void'(q2.pop_front());
      if (o4) void'(q4.pop_front());
      if (p2) q2.push_back({in_PC, in_Instruction});
      if (p4) q4.push_back({in_PC, in_Instruction});
    end
  end

  task automatic mon(input string tag, input int dep, input int sz, input logic [63:0] head,
                     input logic ov, input logic ir, input logic [63:0] cnt,
                     input logic [31:0] pc, input logic [31:0] fields, input logic [15:0] imm);
    check({tag, ".count"},     cnt, 64'(sz));
    check({tag, ".in_ready"},  64'(ir), 64'(sz < dep));
    check({tag, ".out_valid"}, 64'(ov), 64'(sz != 0));
    check({tag, ".out_PC"},    64'(pc), (sz != 0) ? 64'(head[63:32]) : 64'd0);
    check({tag, ".fields"},    64'(fields), (sz != 0) ? 64'(head[31:0]) : 64'd0);
    check({tag, ".Imm16"},     64'(imm), (sz != 0) ? 64'(head[15:0]) : 64'd0);
  endtask

  always @(negedge clk) begin
    mon("d2", 2, q2.size(), (q2.size() != 0) ? q2[0] : 64'd0, b2.out_valid, b2.in_ready,
        64'(b2.count), b2.out_PC,
        {b2.out_Opcode, b2.out_rs, b2.out_rt, b2.out_rd, b2.out_shamt, b2.out_Funct},
        b2.out_Imm16);
    mon("d4", 4, q4.size(), (q4.size() != 0) ? q4[0] : 64'd0, b4.out_valid, b4.in_ready,
        64'(b4.count), b4.out_PC,
        {b4.out_Opcode, b4.out_rs, b4.out_rt, b4.out_rd, b4.out_shamt, b4.out_Funct},
        b4.out_Imm16);
  end

  // Applies one cycle of inputs and returns 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic ordy, input logic fl);
    in_valid = v; in_PC = pc; in_Instruction = ins; out_ready = ordy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count",    64'(b2.count), 64'd0);
    check("rst_in_ready", 64'(b2.in_ready), 64'd1);
    check("rst_valid",    64'(b2.out_valid), 64'd0);
    check("rst_pc",       64'(b2.out_PC), 64'd0);
    rst = 1'b1;

    // Bubble masking
    cyc(1'b0, 32'h100, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("bubble_imm",    64'(b2.out_Imm16), 64'd0);
    check("bubble_opcode", 64'(b2.out_Opcode), 64'd0);
    check("bubble_pc",     64'(b2.out_PC), 64'd0);

    // Streaming with out_ready held high
    cyc(1'b1, 32'h0, 32'h012A_4020, 1'b1, 1'b0);
    check("stream_opcode", 64'(b2.out_Opcode), 64'd0);
    check("stream_rs",     64'(b2.out_rs), 64'd9);
    check("stream_rt",     64'(b2.out_rt), 64'd10);
    check("stream_rd",     64'(b2.out_rd), 64'd8);
    check("stream_funct",  64'(b2.out_Funct), 64'h20);
    cyc(1'b1, 32'h4, 32'h8D28_0004, 1'b1, 1'b0);
    check("stream_count1", 64'(b2.count), 64'd1);
    check("stream_pc4",    64'(b2.out_PC), 64'h4);
    cyc(1'b1, 32'h8, 32'h3C01_ABCD, 1'b1, 1'b0);
    check("stream_count2", 64'(b2.count), 64'd1);
    check("stream_imm",    64'(b2.out_Imm16), 64'hABCD);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("stream_drain",  64'(b2.count), 64'd0);

    // Backpressure and fill
    cyc(1'b1, 32'h0, 32'h1111_1111, 1'b0, 1'b0);
    cyc(1'b1, 32'h4, 32'h2222_2222, 1'b0, 1'b0);
    check("bp_count",    64'(b2.count), 64'd2);
    check("bp_in_ready", 64'(b2.in_ready), 64'd0);
    cyc(1'b1, 32'h8, 32'h3333_3333, 1'b0, 1'b0);
    check("bp_count3",   64'(b2.count), 64'd2);
    check("bp_head",     64'(b2.out_PC), 64'h0);
    check("bp_d4_count", 64'(b4.count), 64'd3);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("bp_pop1_pc",  64'(b2.out_PC), 64'h4);
    check("bp_refill",   64'(b2.in_ready), 64'd1);
    repeat (3) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with an instruction offered
    cyc(1'b1, 32'h10, 32'hAAAA_0001, 1'b0, 1'b0);
    cyc(1'b1, 32'h14, 32'hAAAA_0002, 1'b0, 1'b0);
    check("fl_pre_count", 64'(b2.count), 64'd2);
    cyc(1'b1, 32'h20, 32'hDEAD_BEEF, 1'b0, 1'b1);
    check("fl_valid",    64'(b2.out_valid), 64'd0);
    check("fl_count",    64'(b2.count), 64'd0);
    check("fl_in_ready", 64'(b2.in_ready), 64'd1);
    check("fl_fields",   64'({b2.out_Opcode, b2.out_rs, b2.out_rt, b2.out_rd,
                             b2.out_shamt, b2.out_Funct}), 64'd0);
    check("fl_d4_count", 64'(b4.count), 64'd0);
    cyc(1'b1, 32'h24, 32'h0000_0024, 1'b0, 1'b0);
    check("fl_post_pc",  64'(b2.out_PC), 64'h24);
    repeat (3) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-run
    cyc(1'b1, 32'h30, 32'h0000_0030, 1'b0, 1'b0);
    cyc(1'b1, 32'h34, 32'h0000_0034, 1'b0, 1'b0);
    check("ar_pre_count", 64'(b2.count), 64'd2);
    #2 rst = 1'b0;
    #1;
    check("ar_count",    64'(b2.count), 64'd0);
    check("ar_in_ready", 64'(b2.in_ready), 64'd1);
    check("ar_valid",    64'(b2.out_valid), 64'd0);
    check("ar_pc",       64'(b2.out_PC), 64'd0);
    check("ar_d4_count", 64'(b4.count), 64'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;

    // Near-full churn so the DEPTH=4 pointers wrap repeatedly
    repeat (60) cyc(1'b1, $urandom & 32'hFFFF_FFFC, $urandom,
                    ($urandom_range(0, 3) == 0), 1'b0);

    // Fully random traffic with occasional flushes
    repeat (400) cyc(($urandom_range(0, 9) < 7), $urandom & 32'hFFFF_FFFC, $urandom,
                     $urandom_range(0, 1) == 1, ($urandom_range(0, 31) == 0));

    repeat (6) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("final_empty", 64'(b4.count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
